// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction
endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory read port: req/addr held until ack, ack may coincide with req.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_pc_gen.sv
// Next fetch-PC select: redirect target, queued target or sequential step, else hold.
module if_pc_gen
    import if_fetch_pkg::*;
(
    input  logic [ADDR_W-1:0] cur_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              pend,
    input  logic [ADDR_W-1:0] pend_pc,
    input  logic              step,
    output logic [ADDR_W-1:0] next_pc
);
    always_comb begin
        next_pc = cur_pc;
        if (redirect) begin
            next_pc = word_align(redirect_pc);
        end else if (step) begin
            // Sequential step wraps naturally at 2^ADDR_W.
            next_pc = pend ? pend_pc : cur_pc + ADDR_W'(PC_STEP);
        end
    end
endmodule

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage with req/ack memory port, 1-entry skid and branch redirect.
// Optional macro IF_DELAY_SLOT_EN: deliver the in-flight/skid instruction at a redirect instead of squashing it.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    if_fetch_if.master        imem,
    output logic [ADDR_W-1:0] pc_if,
    output logic [DATA_W-1:0] inst_if,
    output logic              en_if
);
`ifdef IF_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] fetch_pc, next_pc;
    logic              redir_pend;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_inst;

    logic              redirect, drop, ack_step;
    logic              out_load, out_en_nx, skid_load, pc_upd, pend_set, pend_clr;
    logic [ADDR_W-1:0] out_pc_nx;
    logic [DATA_W-1:0] out_inst_nx;

    assign redirect  = br_taken & ~stall;
    assign drop      = ~DELAY_SLOT & (redir_pend | redirect);
    assign ack_step  = (state == S_REQ) & imem.ack;
    assign imem.req  = (state == S_REQ);
    assign imem.addr = fetch_pc;

    if_pc_gen u_pc_gen (
        .cur_pc      (fetch_pc),
        .redirect    (redirect),
        .redirect_pc (br_addr),
        .pend        (redir_pend),
        .pend_pc     (redir_pc),
        .step        (ack_step),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        out_load    = 1'b0;
        out_en_nx   = 1'b0;
        out_pc_nx   = '0;
        out_inst_nx = '0;
        skid_load   = 1'b0;
        pc_upd      = 1'b0;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!stall) begin
                    state_nx = S_REQ;
                    out_load = 1'b1;
                    pc_upd   = 1'b1;
                end
            end
            S_REQ: begin
                if (imem.ack) begin
                    pc_upd   = 1'b1;
                    pend_clr = 1'b1;
                    if (drop) begin
                        out_load = ~stall;
                    end else if (!stall) begin
                        out_load    = 1'b1;
                        out_en_nx   = 1'b1;
                        out_pc_nx   = fetch_pc;
                        out_inst_nx = imem.rdata;
                    end else begin
                        skid_load = 1'b1;
                        state_nx  = S_FULL;
                    end
                end else begin
                    // Address must stay put while the request is open, so the target is queued.
                    pend_set = redirect;
                    out_load = ~stall;
                end
            end
            S_FULL: begin
                if (!stall) begin
                    state_nx = S_REQ;
                    out_load = 1'b1;
                    pc_upd   = 1'b1;
                    if (DELAY_SLOT || !redirect) begin
                        out_en_nx   = 1'b1;
                        out_pc_nx   = skid_pc;
                        out_inst_nx = skid_inst;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            fetch_pc   <= RESET_PC;
            redir_pend <= 1'b0;
            pc_if      <= '0;
            inst_if    <= '0;
            en_if      <= 1'b0;
        end else begin
            if (pc_upd) fetch_pc <= next_pc;
            if (pend_set)      redir_pend <= 1'b1;
            else if (pend_clr) redir_pend <= 1'b0;
            if (out_load) begin
                en_if   <= out_en_nx;
                pc_if   <= out_pc_nx;
                inst_if <= out_inst_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pend_set) redir_pc <= word_align(br_addr);
        if (skid_load) begin
            skid_pc   <= fetch_pc;
            skid_inst <= imem.rdata;
        end
    end

    // ID must never redirect while it is itself stalled.
    a_no_redirect_in_stall: assert property (@(posedge clk) disable iff (!reset_) !(br_taken && stall));
endmodule
